// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared types and constants for the HI/LO multiply unit
// Optional MADD/MADDU support in the top is enabled by HILO_MULT_ACCUM_EN.
package hilo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int LATENCY   = DEF_WIDTH + 2;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FIX,
    ACC,
    WB
  } state_t;

endpackage

// File: rtl/hilo_mul_step.sv
// rtl/hilo_mul_step.sv - one radix-2 shift-add iteration on the product accumulator
module hilo_mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               add,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic           unused_lsb;

  // The 65th bit carries the add overflow so the right shift never loses it.
  assign sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (add ? mcand : {WIDTH{1'b0}})};
  assign acc_next   = {sum, acc[WIDTH-1:1]};
  assign unused_lsb = acc[0];

endmodule

// File: rtl/hilo_mult_unit.sv
// rtl/hilo_mult_unit.sv - multi-cycle MULT/MULTU with HI/LO registers and move/read stall
// Define HILO_MULT_ACCUM_EN to add the accum port and the MADD/MADDU ACC state.
module hilo_mult_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef HILO_MULT_ACCUM_EN
  input  logic             accum,
`endif
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mfhi,
  input  logic             mflo,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               neg;
`ifdef HILO_MULT_ACCUM_EN
  logic               accum_q;
`endif

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  hilo_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .add      (mplier[cnt]),
    .acc_next (step_acc)
  );

  assign busy    = (state != IDLE);
  assign stall   = busy & (mfhi | mflo | mthi | mtlo);
  assign rd_data = mfhi ? hi : (mflo ? lo : {WIDTH{1'b0}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
`ifdef HILO_MULT_ACCUM_EN
      accum_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Moves issued alongside start land now and are overwritten at WB.
          if (mthi) hi <= wr_data;
          if (mtlo) lo <= wr_data;
          if (start) begin
            mcand   <= magnitude(op_a, is_signed);
            mplier  <= magnitude(op_b, is_signed);
            neg     <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc     <= '0;
            cnt     <= '0;
`ifdef HILO_MULT_ACCUM_EN
            accum_q <= accum;
`endif
            state   <= RUN;
          end
        end
        RUN: begin
          acc <= step_acc;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (neg) acc <= -acc;
`ifdef HILO_MULT_ACCUM_EN
          state <= accum_q ? ACC : WB;
`else
          state <= WB;
`endif
        end
        ACC: begin
          acc   <= {hi, lo} + acc;
          state <= WB;
        end
        WB: begin
          hi    <= acc[2*WIDTH-1:WIDTH];
          lo    <= acc[WIDTH-1:0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Multi-cycle multiply unit with its HI/LO result registers. It sits downstream of the ALU multiply path and is the sequential consumer of the 64-bit product.
- Accepts MULT/MULTU requests and runs a radix-2 shift-add loop, one multiplier bit per clock. It commits the product to HI/LO.
- Services MFHI/MFLO/MTHI/MTLO and stalls the pipeline while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  multiply request; accepted only in IDLE
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU
- op_a  in  WIDTH  multiplicand
- op_b  in  WIDTH  multiplier
- mthi  in  1  write wr_data to HI
- mtlo  in  1  write wr_data to LO
- wr_data  in  WIDTH  move-to data
- mfhi  in  1  read HI on rd_data
- mflo  in  1  read LO on rd_data
- rd_data  out  WIDTH  combinational: mfhi ? hi : (mflo ? lo : 0)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  multiply in flight
- stall  out  1  busy & (mfhi | mflo | mthi | mtlo)
- done  out  1  one-cycle pulse when HI/LO take the new product

Behaviour:
- Reset is asynchronous and active-high. While reset=1: state=IDLE, hi=0, lo=0, busy=0, done=0, internal accumulator and counter=0.
- Reset mid-operation aborts the multiply immediately. No partial result reaches HI/LO.
- States:
  - IDLE: start=1 at edge N latches the operands and goes to RUN.
    - Magnitudes: if is_signed and op[31]=1, the stored value is the two's complement of the operand. 0x80000000 maps to magnitude 0x80000000.
    - neg_flag = is_signed & (op_a[31] ^ op_b[31]).
    - The 2·WIDTH accumulator and counter are cleared.
  - RUN: each cycle, if mplier[cnt]=1, acc[63:32] += mcand, with the carry kept in a 65th bit. Then acc is shifted right by 1 and cnt is incremented. Leave RUN after WIDTH iterations, i.e. when cnt wraps from WIDTH-1.
  - FIX: if neg_flag, acc = -acc (64-bit). Go to WB.
  - WB: hi=acc[63:32], lo=acc[31:0] at this edge. done=1 for the following cycle. Return to IDLE.
- Latency: start sampled at edge N. busy=1 from after edge N through edge N+WIDTH+2. HI/LO are updated at edge N+WIDTH+2 (N+34 for WIDTH=32). done is high in the cycle after that edge and busy is low in that same cycle.
- busy=1 in RUN, FIX and WB.
- start while busy is ignored; no queueing.
- mthi/mtlo in IDLE write at the clock edge.
  - If they occur in the same cycle as start, the move is applied and is later overwritten at WB.
  - mthi and mtlo together write both registers.
- Move/read requests while busy raise stall. Moves are not applied. The requester holds the request until stall drops.
- rd_data is always driven. Reads during busy return the old HI/LO (qualified by stall). mfhi has priority over mflo.

Optional Feature:
- Macro HILO_MULT_ACCUM_EN adds input port accum (1 bit), sampled with start, implementing MADD/MADDU.
- With the macro: an extra ACC state follows FIX and performs {hi,lo} = {hi,lo} + acc (mod 2^64). Accumulating operations take 1 extra cycle: the WB edge is N+WIDTH+3.
- Without the macro: no accum port, no ACC state; behaviour is exactly as above.

Decomposition:
- Package hilo_pkg holds:
  - the state enum (IDLE, RUN, FIX, ACC, WB);
  - the WIDTH default;
  - the LATENCY constant = WIDTH+2;
  - the counter width = clog2(WIDTH).
- Sub-module hilo_mul_step: purely combinational single shift-add iteration (acc, mcand, bit) -> next acc. It is instantiated once by the FSM.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start; busy high 34 cycles.
- MULT 0xFFFFFFFD(-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- mfhi asserted 5 cycles after start of 3x4 -> stall=1 until the done cycle; afterwards rd_data=0x00000000 for hi and 0x0000000C for lo. start pulsed again mid-run -> ignored; result unchanged.
- mthi 0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle. mtlo during busy -> stall=1, lo unchanged until the request is retried after done.
- reset asserted at RUN iteration 10 (prior hi/lo=0x1234/0x5678) -> hi=lo=0, busy=0 immediately without a clock edge; no done pulse.
- (HILO_MULT_ACCUM_EN) hi=0, lo=5, MADDU 2x3 with accum=1 -> lo=0x0000000B, hi=0, done at 35 cycles. hi=0, lo=0xFFFFFFFF, MADDU 1x1 -> hi=1, lo=0.
